etapa_mem_multiciclo: RTL and testbench

//  MIPS MEM pipeline stage: byte-addressable data memory plus the MEM/WB pipeline register.

---
 rtl/etapa_mem_multiciclo.sv | 206 ++++++++++++++++++++
 tb/tb_etapa_mem_multiciclo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_mem_multiciclo.sv
// MIPS MEM stage with multi-cycle loads: byte-addressable data memory plus
// the MEM/WB pipeline register. Loads take RD_LATENCY cycles and hold the
// upstream pipeline through o_stall; stores always complete in one edge.
// Optional feature macro: MEM_ALIGN_CHECK_EN (flags misaligned half/word
// accesses, drops their stores and zeroes their load data; adds o_misaligned).

// Per-byte-lane store steering: picks the byte of store data that lands in
// this lane and decides whether the lane is written for the current access.
module etapa_mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] i_boff,
  input  logic       i_is_byte,
  input  logic       i_is_half,
  input  logic [7:0] i_b_byte,
  input  logic [7:0] i_b_half,
  input  logic [7:0] i_b_word,
  output logic       o_be,
  output logic [7:0] o_wdata
);
  localparam logic [1:0] L = 2'(LANE);

  // Lane enable and lane data from access size and byte offset
  always_comb begin
    o_be    = 1'b1;
    o_wdata = i_b_word;
    if (i_is_byte) begin
      o_be    = (i_boff == L);
      o_wdata = i_b_byte;
    end else if (i_is_half) begin
      o_be    = (i_boff[1] == L[1]);
      o_wdata = i_b_half;
    end
  end
endmodule

module etapa_mem_multiciclo #(
  parameter int MEM_DEPTH  = 64,
  parameter int RD_LATENCY = 1,
  parameter int REG_W      = 5
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_halt,
  input  logic [REG_W-1:0]             i_write_reg,
  input  logic [31:0]                  i_data_to_write_in_MEM,
  input  logic [31:0]                  i_ALU_result,
  input  logic                         i_WB_write,
  input  logic                         i_WB_mem_to_reg,
  input  logic                         i_MEM_read,
  input  logic                         i_MEM_write,
  input  logic                         i_MEM_unsigned,
  input  logic [1:0]                   i_MEM_byte_half_word,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
  output logic                         o_WB_write,
  output logic                         o_WB_mem_to_reg,
  output logic [31:0]                  o_ALU_result,
  output logic [31:0]                  o_read_data,
  output logic [REG_W-1:0]             o_write_reg,
  output logic                         o_stall,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                         o_misaligned,
`endif
  output logic [31:0]                  o_debug_data
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LATENCY - 1);

  logic [31:0]      r_mem [MEM_DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_WB_write;
  logic             r_WB_mem_to_reg;
  logic [31:0]      r_ALU_result;
  logic [31:0]      r_read_data;
  logic [REG_W-1:0] r_write_reg;

  logic [AW-1:0]    w_word_idx;
  logic [1:0]       w_boff;
  logic             w_is_byte;
  logic             w_is_half;
  logic             w_misaligned;
  logic             w_load;
  logic             w_stall;
  logic             w_store_en;
  logic [3:0]       w_be;
  logic [3:0][7:0]  w_lane_data;
  logic [31:0]      w_rword;
  logic [7:0]       w_rbyte;
  logic [15:0]      w_rhalf;
  logic [31:0]      w_ext;
  logic [31:0]      w_load_data;

  // Address decode: upper address bits beyond the memory wrap silently
  assign w_word_idx = i_ALU_result[AW+1:2];
  assign w_boff     = i_ALU_result[1:0];
  assign w_is_byte  = (i_MEM_byte_half_word == 2'b00);
  assign w_is_half  = (i_MEM_byte_half_word == 2'b01);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = (w_is_half && w_boff[0]) ||
                        (i_MEM_byte_half_word[1] && (w_boff != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // A simultaneous store cancels the load, so it never stalls
  assign w_load     = i_MEM_read && !i_MEM_write;
  assign w_stall    = w_load && (RD_LATENCY > 1) && (r_cnt != CNT_LAST);
  assign o_stall    = w_stall;
  // Reset and halt both keep the memory untouched
  assign w_store_en = i_MEM_write && !i_halt && i_reset && !w_misaligned;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    etapa_mem_lane #(.LANE(l)) u_lane (
      .i_boff    (w_boff),
      .i_is_byte (w_is_byte),
      .i_is_half (w_is_half),
      .i_b_byte  (i_data_to_write_in_MEM[7:0]),
      .i_b_half  (i_data_to_write_in_MEM[8*(l%2) +: 8]),
      .i_b_word  (i_data_to_write_in_MEM[8*l +: 8]),
      .o_be      (w_be[l]),
      .o_wdata   (w_lane_data[l])
    );
  end

  // Byte-lane masked store into the selected word
  always_ff @(posedge i_clk) begin
    if (w_store_en) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_word_idx][8*l +: 8] <= w_lane_data[l];
      end
    end
  end

  assign w_rword = r_mem[w_word_idx];

  // Little-endian lane extraction for byte and half loads
  always_comb begin
    w_rbyte = w_rword[7:0];
    case (w_boff)
      2'd1:    w_rbyte = w_rword[15:8];
      2'd2:    w_rbyte = w_rword[23:16];
      2'd3:    w_rbyte = w_rword[31:24];
      default: w_rbyte = w_rword[7:0];
    endcase
    w_rhalf = w_boff[1] ? w_rword[31:16] : w_rword[15:0];
  end

  // Sign/zero extension by access size
  always_comb begin
    w_ext = w_rword;
    if (w_is_byte)
      w_ext = i_MEM_unsigned ? {24'd0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
    else if (w_is_half)
      w_ext = i_MEM_unsigned ? {16'd0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
  end

  assign w_load_data = (w_load && !w_misaligned) ? w_ext : 32'd0;

  // MEM/WB register and load-latency counter; stall edges insert a bubble
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt           <= '0;
      r_WB_write      <= 1'b0;
      r_WB_mem_to_reg <= 1'b0;
      r_ALU_result    <= 32'd0;
      r_read_data     <= 32'd0;
      r_write_reg     <= '0;
    end else if (!i_halt) begin
      if (w_stall) begin
        r_cnt      <= r_cnt + CW'(1);
        r_WB_write <= 1'b0;
      end else begin
        r_cnt           <= '0;
        r_WB_write      <= i_WB_write;
        r_WB_mem_to_reg <= i_WB_mem_to_reg;
        r_ALU_result    <= i_ALU_result;
        r_read_data     <= w_load_data;
        r_write_reg     <= i_write_reg;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misaligned;

  // Misalignment flag follows the same capture edges as the MEM/WB register
  always_ff @(posedge i_clk) begin
    if (!i_reset)
      r_misaligned <= 1'b0;
    else if (!i_halt && !w_stall)
      r_misaligned <= (i_MEM_read || i_MEM_write) && w_misaligned;
  end

  assign o_misaligned = r_misaligned;
`endif

  assign o_WB_write      = r_WB_write;
  assign o_WB_mem_to_reg = r_WB_mem_to_reg;
  assign o_ALU_result    = r_ALU_result;
  assign o_read_data     = r_read_data;
  assign o_write_reg     = r_write_reg;
  assign o_debug_data    = r_mem[i_debug_addr];

endmodule

// File: tb/tb_etapa_mem_multiciclo.sv
// Bench for etapa_mem_multiciclo: one single-cycle instance (RD_LATENCY=1)
// and one multi-cycle instance (RD_LATENCY=3). Directed stimulus pushes the
// expected MEM/WB contents into per-instance queues; a monitor pops them on
// every capture edge. Build with MEM_ALIGN_CHECK_EN to cover that option.
module tb_etapa_mem_multiciclo;

  typedef struct packed {
    logic        halt;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] alu;
    logic        wb;
    logic        m2r;
    logic        rd;
    logic        wr;
    logic        uns;
    logic [1:0]  bhw;
  } in_t;

  typedef struct packed {
    logic        wb;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  wreg;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  in_t  a1, a3;
  logic [5:0] dbga1, dbga3;

  logic        wb1, m2r1, st1, wb3, m2r3, st3;
  logic [31:0] alu1, rdat1, dbg1, alu3, rdat3, dbg3;
  logic [4:0]  wreg1, wreg3;
  out_t o1, o3;
  assign o1 = {wb1, m2r1, alu1, rdat1, wreg1};
  assign o3 = {wb3, m2r3, alu3, rdat3, wreg3};
`ifdef MEM_ALIGN_CHECK_EN
  logic mis1, mis3;
`endif

  int n_run = 0;
  int n_fail = 0;
  out_t q1[$];
  out_t q3[$];
  out_t last1;
  logic cap1 = 1'b0, stl1 = 1'b0, cap3 = 1'b0, stl3 = 1'b0;

  always #5 clk = ~clk;

  etapa_mem_multiciclo #(.MEM_DEPTH(64), .RD_LATENCY(1), .REG_W(5)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_halt(a1.halt), .i_write_reg(a1.wreg),
    .i_data_to_write_in_MEM(a1.wdata), .i_ALU_result(a1.alu),
    .i_WB_write(a1.wb), .i_WB_mem_to_reg(a1.m2r), .i_MEM_read(a1.rd),
    .i_MEM_write(a1.wr), .i_MEM_unsigned(a1.uns),
    .i_MEM_byte_half_word(a1.bhw), .i_debug_addr(dbga1),
    .o_WB_write(wb1), .o_WB_mem_to_reg(m2r1), .o_ALU_result(alu1),
    .o_read_data(rdat1), .o_write_reg(wreg1), .o_stall(st1),
`ifdef MEM_ALIGN_CHECK_EN
    .o_misaligned(mis1),
`endif
    .o_debug_data(dbg1));

  etapa_mem_multiciclo #(.MEM_DEPTH(64), .RD_LATENCY(3), .REG_W(5)) dut3 (
    .i_clk(clk), .i_reset(rst_n), .i_halt(a3.halt), .i_write_reg(a3.wreg),
    .i_data_to_write_in_MEM(a3.wdata), .i_ALU_result(a3.alu),
    .i_WB_write(a3.wb), .i_WB_mem_to_reg(a3.m2r), .i_MEM_read(a3.rd),
    .i_MEM_write(a3.wr), .i_MEM_unsigned(a3.uns),
    .i_MEM_byte_half_word(a3.bhw), .i_debug_addr(dbga3),
    .o_WB_write(wb3), .o_WB_mem_to_reg(m2r3), .o_ALU_result(alu3),
    .o_read_data(rdat3), .o_write_reg(wreg3), .o_stall(st3),
`ifdef MEM_ALIGN_CHECK_EN
    .o_misaligned(mis3),
`endif
    .o_debug_data(dbg3));

  function automatic in_t mk(input logic w, input logic r, input logic u,
                             input logic [1:0] bh, input logic [31:0] ad,
                             input logic [31:0] wd, input logic wbw,
                             input logic mr, input logic [4:0] rg);
    in_t t;
    t = '0;
    t.wr = w; t.rd = r; t.uns = u; t.bhw = bh; t.alu = ad; t.wdata = wd;
    t.wb = wbw; t.m2r = mr; t.wreg = rg;
    return t;
  endfunction

  function automatic out_t mo(input logic wbw, input logic mr,
                              input logic [31:0] ad, input logic [31:0] rdv,
                              input logic [4:0] rg);
    out_t t;
    t.wb = wbw; t.m2r = mr; t.alu = ad; t.rdata = rdv; t.wreg = rg;
    return t;
  endfunction

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got wb=%0b m2r=%0b alu=%h rdata=%h wreg=%0d, want wb=%0b m2r=%0b alu=%h rdata=%h wreg=%0d",
               nm, act.wb, act.m2r, act.alu, act.rdata, act.wreg,
               exp.wb, exp.m2r, exp.alu, exp.rdata, exp.wreg);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Capture / stall edge markers, sampled with pre-edge values
  always @(posedge clk) begin
    cap1 <= rst_n && !a1.halt && !st1;
    stl1 <= rst_n && !a1.halt && st1;
    cap3 <= rst_n && !a3.halt && !st3;
    stl3 <= rst_n && !a3.halt && st3;
  end

  // Monitor: pop and compare on capture edges, check bubbles on stall edges
  always @(negedge clk) begin
    out_t e;
    if (cap1 && q1.size() > 0) begin
      e = q1.pop_front();
      chk_out("mem1", o1, e);
    end
    if (cap3 && q3.size() > 0) begin
      e = q3.pop_front();
      chk_out("mem3", o3, e);
    end
    if (stl1) chk32("bubble1", {31'd0, wb1}, 32'd0);
    if (stl3) chk32("bubble3", {31'd0, wb3}, 32'd0);
  end

  // Wait (bounded) for the next capture edge, counting stall edges before it
  task automatic wait_cap(input int which, output int nst);
    bit done;
    done = 0;
    nst = 0;
    for (int k = 0; k < 16 && !done; k++) begin
      @(negedge clk);
      if ((which == 1) ? cap1 : cap3) done = 1;
      else if ((which == 1) ? stl1 : stl3) nst++;
    end
    if (!done) begin
      n_run++;
      n_fail++;
      $display("FAIL cap_timeout: dut%0d no capture within 16 cycles", which);
    end
  endtask

  task automatic issue(input int which, input in_t in, input out_t exp, output int nst);
    if (which == 1) begin a1 = in; q1.push_back(exp); last1 = exp; end
    else begin a3 = in; q3.push_back(exp); end
    wait_cap(which, nst);
  endtask

  initial begin
    int n;
    out_t ex;
    rst_n = 1'b0;
    a1 = '0; a3 = '0; a3.halt = 1'b1;
    dbga1 = '0; dbga3 = '0;
    repeat (2) @(negedge clk);
    chk_out("rst1", o1, '0);
    chk_out("rst3", o3, '0);
    chk32("rst_stall1", {31'd0, st1}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk32("rst_mis1", {31'd0, mis1}, 32'd0);
`endif
    rst_n = 1'b1;

    // ---- single-cycle instance ----
    for (int j = 0; j < 20; j++)
      issue(1, mk(1, 0, 0, 2'b11, 32'(4*j), 32'(j), 0, 0, 5'd0),
            mo(0, 0, 32'(4*j), 32'd0, 5'd0), n);
    for (int j = 0; j < 20; j++)
      issue(1, mk(0, 1, 0, 2'b11, 32'(4*j), 32'd0, 1, 1, j[4:0]),
            mo(1, 1, 32'(4*j), 32'(j), j[4:0]), n);

    issue(1, mk(1, 0, 0, 2'b11, 32'h4, 32'h0, 0, 0, 5'd0), mo(0, 0, 32'h4, 32'h0, 5'd0), n);
    issue(1, mk(1, 0, 0, 2'b00, 32'h5, 32'h123456AB, 0, 0, 5'd0), mo(0, 0, 32'h5, 32'h0, 5'd0), n);
    issue(1, mk(0, 1, 0, 2'b00, 32'h5, 32'h0, 1, 1, 5'd1), mo(1, 1, 32'h5, 32'hFFFFFFAB, 5'd1), n);
    issue(1, mk(0, 1, 1, 2'b00, 32'h5, 32'h0, 1, 1, 5'd2), mo(1, 1, 32'h5, 32'h000000AB, 5'd2), n);
    issue(1, mk(0, 1, 0, 2'b11, 32'h4, 32'h0, 1, 1, 5'd3), mo(1, 1, 32'h4, 32'h0000AB00, 5'd3), n);
    issue(1, mk(0, 1, 0, 2'b01, 32'h4, 32'h0, 1, 1, 5'd4), mo(1, 1, 32'h4, 32'hFFFFAB00, 5'd4), n);
    issue(1, mk(1, 0, 0, 2'b01, 32'h6, 32'hFFFF8001, 0, 0, 5'd0), mo(0, 0, 32'h6, 32'h0, 5'd0), n);
    issue(1, mk(0, 1, 1, 2'b01, 32'h6, 32'h0, 1, 1, 5'd5), mo(1, 1, 32'h6, 32'h00008001, 5'd5), n);
    issue(1, mk(0, 1, 0, 2'b01, 32'h6, 32'h0, 1, 1, 5'd6), mo(1, 1, 32'h6, 32'hFFFF8001, 5'd6), n);
    // store and load together: store wins, read data latches 0
    issue(1, mk(1, 1, 0, 2'b11, 32'h8, 32'h11223344, 1, 1, 5'd7), mo(1, 1, 32'h8, 32'h0, 5'd7), n);
    issue(1, mk(0, 1, 1, 2'b00, 32'hB, 32'h0, 1, 1, 5'd8), mo(1, 1, 32'hB, 32'h00000011, 5'd8), n);
    // address wrap: 0x108 maps to word 2
    issue(1, mk(0, 1, 0, 2'b11, 32'h108, 32'h0, 1, 1, 5'd9), mo(1, 1, 32'h108, 32'h11223344, 5'd9), n);
`ifdef MEM_ALIGN_CHECK_EN
    ex = mo(1, 1, 32'hB, 32'h0, 5'd10);
`else
    ex = mo(1, 1, 32'hB, 32'h11223344, 5'd10);
`endif
    issue(1, mk(0, 1, 0, 2'b11, 32'hB, 32'h0, 1, 1, 5'd10), ex, n);
`ifdef MEM_ALIGN_CHECK_EN
    chk32("mis_load", {31'd0, mis1}, 32'd1);
    issue(1, mk(1, 0, 0, 2'b11, 32'h6, 32'hFFFFFFFF, 0, 0, 5'd0), mo(0, 0, 32'h6, 32'h0, 5'd0), n);
    chk32("mis_store", {31'd0, mis1}, 32'd1);
    issue(1, mk(0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 5'd0), mo(0, 0, 32'h0, 32'h0, 5'd0), n);
    chk32("mis_clear", {31'd0, mis1}, 32'd0);
`endif
    dbga1 = 6'd1; #1;
    chk32("dbg1_w1", dbg1, 32'h8001AB00);
    dbga1 = 6'd2; #1;
    chk32("dbg1_w2", dbg1, 32'h11223344);

    // halt with a store presented: nothing moves
    a1 = mk(1, 0, 0, 2'b11, 32'h0, 32'h0000DEAD, 1, 0, 5'd3);
    a1.halt = 1'b1;
    dbga1 = 6'd0;
    repeat (3) @(negedge clk);
    chk_out("halt1_hold", o1, last1);
    chk32("halt1_mem", dbg1, 32'h0);
    issue(1, mk(0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 5'd0), mo(0, 0, 32'h0, 32'h0, 5'd0), n);
    chk32("halt1_mem_after", dbg1, 32'h0);
    a1 = '0; a1.halt = 1'b1;

    // ---- RD_LATENCY=3 instance ----
    issue(3, mk(1, 0, 0, 2'b11, 32'h8, 32'hCAFEF00D, 1, 0, 5'd3), mo(1, 0, 32'h8, 32'h0, 5'd3), n);
    chk32("st3_nostall", 32'(n), 32'd0);
    issue(3, mk(0, 1, 0, 2'b11, 32'h8, 32'h0, 1, 1, 5'd7), mo(1, 1, 32'h8, 32'hCAFEF00D, 5'd7), n);
    chk32("ld3_stalls", 32'(n), 32'd2);
    issue(3, mk(0, 1, 0, 2'b00, 32'hA, 32'h0, 1, 1, 5'd8), mo(1, 1, 32'hA, 32'hFFFFFFFE, 5'd8), n);
    chk32("ld3b_stalls", 32'(n), 32'd2);
    issue(3, mk(1, 0, 0, 2'b11, 32'h10, 32'h87654321, 1, 0, 5'd0), mo(1, 0, 32'h10, 32'h0, 5'd0), n);

    // halt after the first stall edge (cnt=1)
    a3 = mk(0, 1, 0, 2'b01, 32'h12, 32'h0, 1, 1, 5'd9);
    q3.push_back(mo(1, 1, 32'h12, 32'hFFFF8765, 5'd9));
    @(negedge clk);
    a3.halt = 1'b1;
    dbga3 = 6'd4;
    repeat (4) @(negedge clk);
    chk_out("halt3_hold", o3, mo(0, 0, 32'h10, 32'h0, 5'd0));
    chk32("halt3_stall", {31'd0, st3}, 32'd1);
    chk32("halt3_mem", dbg3, 32'h87654321);
    a3.halt = 1'b0;
    wait_cap(3, n);
    chk32("halt3_resume", 32'(n), 32'd1);

    // reset in the middle of a load restarts the count
    a3 = mk(0, 1, 1, 2'b01, 32'h10, 32'h0, 1, 1, 5'd4);
    q3.push_back(mo(1, 1, 32'h10, 32'h00004321, 5'd4));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("rst3_mid", o3, '0);
    chk32("rst3_stall", {31'd0, st3}, 32'd1);
    rst_n = 1'b1;
    wait_cap(3, n);
    chk32("rst3_restart", 32'(n), 32'd2);
    dbga3 = 6'd2; #1;
    chk32("dbg3_w2", dbg3, 32'hCAFEF00D);

    a3 = '0; a3.halt = 1'b1;
    @(negedge clk);
    chk32("q1_empty", 32'(q1.size()), 32'd0);
    chk32("q3_empty", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
